// File: rtl/buffer_access_arbiter.sv
// buffer_access_arbiter
//
// Round-robin owner selection for a shared single-port buffer. Each cycle one
// of MUX_NUM requestors may own the buffer address/data mux; the winner is
// registered into gnt/sel/sel_valid and drives the mux in the following cycle.
// Granted reads are tracked through an RD_LAT-deep pipeline so that the
// returning R_data can be tagged with its owner (rvalid/rsel).
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   req       per-requestor access request (level)
//   rd        per-requestor access type qualifying req: 1 = read, 0 = write
//   lock      per-requestor burst hold, effective while owner and req high
//   gnt       one-hot registered grant (zero when idle)
//   sel       binary index of the current owner, holds when idle
//   sel_valid gnt is non-zero, an access happens this cycle
//   rvalid    one-hot owner of buffer R_data this cycle
//   rsel      binary index of the rvalid owner
//
// Handshake: req[i] is a level request that must stay high (with rd[i] and the
// requestor's addr/data stable) until the requestor observes gnt[i]. Every
// cycle with gnt[i]=1 is exactly one buffer access; there is no backpressure
// on the read return path, so rvalid is a pure valid with no ready.

module buffer_access_arbiter #(
  parameter int MUX_NUM  = 64,
  parameter int SELECT_W = $clog2(MUX_NUM),
  parameter int RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MUX_NUM-1:0]  req,
  input  logic [MUX_NUM-1:0]  rd,
  input  logic [MUX_NUM-1:0]  lock,
  output logic [MUX_NUM-1:0]  gnt,
  output logic [SELECT_W-1:0] sel,
  output logic                sel_valid,
  output logic [MUX_NUM-1:0]  rvalid,
  output logic [SELECT_W-1:0] rsel
);

  localparam int unsigned MUX_U = MUX_NUM;
  localparam logic [MUX_NUM-1:0] ONE_HOT0 = MUX_NUM'(1);

  // (base + off) mod MUX_NUM, valid for off < MUX_NUM and any MUX_NUM,
  // not only powers of two.
  function automatic logic [SELECT_W-1:0] wrap_add(
    input logic [SELECT_W-1:0] base,
    input int unsigned         off
  );
    int unsigned s;
    s = {{(32-SELECT_W){1'b0}}, base} + off;
    if (s >= MUX_U) s = s - MUX_U;
    return s[SELECT_W-1:0];
  endfunction

  // Round-robin pointer: index with highest priority in the next search.
  logic [SELECT_W-1:0] ptr;

  logic                hold;
  logic                found;
  logic [SELECT_W-1:0] win;
  logic [SELECT_W-1:0] cand;
  logic [MUX_NUM-1:0]  nxt_gnt;
  logic [SELECT_W-1:0] nxt_sel;
  logic                nxt_valid;
  logic [SELECT_W-1:0] nxt_ptr;

  always_comb begin
    hold      = sel_valid && lock[sel] && req[sel];
    found     = 1'b0;
    win       = ptr;
    cand      = ptr;
    nxt_gnt   = '0;
    nxt_sel   = sel;
    nxt_valid = 1'b0;
    nxt_ptr   = ptr;

    // First requester at or after the pointer, wrapping around.
    for (int unsigned k = 0; k < MUX_U; k++) begin
      cand = wrap_add(ptr, k);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    if (hold) begin
      // Locked burst: keep the owner, leave the pointer where it is.
      nxt_gnt   = gnt;
      nxt_valid = 1'b1;
    end else if (found) begin
      nxt_gnt   = ONE_HOT0 << win;
      nxt_sel   = win;
      nxt_valid = 1'b1;
      nxt_ptr   = wrap_add(win, 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt       <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
      ptr       <= '0;
    end else begin
      gnt       <= nxt_gnt;
      sel       <= nxt_sel;
      sel_valid <= nxt_valid;
      ptr       <= nxt_ptr;
    end
  end

  // Read tracking: a granted cycle that is a read enters the pipeline at the
  // end of that cycle; the tail of the pipeline is the owner of R_data.
  logic                rd_push;
  logic                rd_v   [RD_LAT];
  logic [SELECT_W-1:0] rd_idx [RD_LAT];

  assign rd_push = sel_valid && req[sel] && rd[sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) begin
        rd_v[k]   <= 1'b0;
        rd_idx[k] <= '0;
      end
    end else begin
      rd_v[0]   <= rd_push;
      rd_idx[0] <= rd_push ? sel : '0;
      for (int k = 1; k < RD_LAT; k++) begin
        rd_v[k]   <= rd_v[k-1];
        rd_idx[k] <= rd_idx[k-1];
      end
    end
  end

  assign rvalid = rd_v[RD_LAT-1] ? (ONE_HOT0 << rd_idx[RD_LAT-1]) : '0;
  assign rsel   = rd_idx[RD_LAT-1];

endmodule

// File: tb/tb_buffer_access_arbiter.sv
// Directed bench for buffer_access_arbiter with MUX_NUM=4. Two instances share
// the request inputs: dut uses RD_LAT=1, dut2 uses RD_LAT=2.

module tb_buffer_access_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] rd;
  logic [3:0] lock;

  logic [3:0] gnt;
  logic [1:0] sel;
  logic       sel_valid;
  logic [3:0] rvalid;
  logic [1:0] rsel;

  logic [3:0] gnt2;
  logic [1:0] sel2;
  logic       sel_valid2;
  logic [3:0] rvalid2;
  logic [1:0] rsel2;

  int n_checks;
  int n_errors;

  buffer_access_arbiter #(.MUX_NUM(4), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .req(req), .rd(rd), .lock(lock),
    .gnt(gnt), .sel(sel), .sel_valid(sel_valid),
    .rvalid(rvalid), .rsel(rsel)
  );

  buffer_access_arbiter #(.MUX_NUM(4), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .req(req), .rd(rd), .lock(lock),
    .gnt(gnt2), .sel(sel2), .sel_valid(sel_valid2),
    .rvalid(rvalid2), .rsel(rsel2)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with the given inputs already presented, then release.
  task automatic do_reset(input logic [3:0] r, input logic [3:0] t,
                          input logic [3:0] l);
    rst  = 1'b1;
    req  = r;
    rd   = t;
    lock = l;
    tick();
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(4'b0000, 4'b0000, 4'b0000);
    n_checks++;
    if ({gnt, sel, sel_valid, rvalid, rsel} !== 13'd0) begin
      n_errors++;
      $display("FAIL reset_state got gnt=%b sel=%0d sv=%b rv=%b rsel=%0d exp all 0",
               gnt, sel, sel_valid, rvalid, rsel);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if ({gnt, sel, sel_valid, rvalid, gnt2, rvalid2} !== 15'd0) begin
        n_errors++;
        $display("FAIL idle_after_reset[%0d] got gnt=%b sel=%0d sv=%b rv=%b gnt2=%b rv2=%b exp 0",
                 c, gnt, sel, sel_valid, rvalid, gnt2, rvalid2);
      end
    end
  endtask

  // All requesting reads, no lock: rotation with no bubbles, read tags follow.
  task automatic test_round_robin();
    logic [3:0] exp_g  [0:4];
    logic [1:0] exp_s  [0:4];
    logic [3:0] exp_rv [0:4];
    logic [3:0] exp_r2 [0:4];
    exp_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_s  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_rv = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_r2 = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100};
    do_reset(4'b1111, 4'b1111, 4'b0000);
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (gnt !== exp_g[c] || sel !== exp_s[c] || sel_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL rr_grant[%0d] got gnt=%b sel=%0d sv=%b exp gnt=%b sel=%0d sv=1",
                 c, gnt, sel, sel_valid, exp_g[c], exp_s[c]);
      end
      n_checks++;
      if (rvalid !== exp_rv[c] || (c > 0 && rsel !== exp_s[c-1])) begin
        n_errors++;
        $display("FAIL rr_rvalid[%0d] got rv=%b rsel=%0d exp rv=%b rsel=%0d",
                 c, rvalid, rsel, exp_rv[c], (c > 0) ? exp_s[c-1] : 2'd0);
      end
      n_checks++;
      if (rvalid2 !== exp_r2[c]) begin
        n_errors++;
        $display("FAIL rr_rvalid_lat2[%0d] got rv2=%b exp rv2=%b", c, rvalid2, exp_r2[c]);
      end
    end
  endtask

  // Sparse requests skip idle channels; writes never return data.
  task automatic test_sparse_and_writes();
    logic [1:0] exp_s [0:2];
    exp_s = '{2'd1, 2'd3, 2'd1};
    do_reset(4'b1010, 4'b1111, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (sel !== exp_s[c] || gnt !== (4'b0001 << exp_s[c])) begin
        n_errors++;
        $display("FAIL sparse_grant[%0d] got gnt=%b sel=%0d exp sel=%0d",
                 c, gnt, sel, exp_s[c]);
      end
    end
    req = 4'b1000;
    rd  = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (gnt !== 4'b1000 || sel !== 2'd3 || rvalid !== 4'b0000) begin
        n_errors++;
        $display("FAIL write_only[%0d] got gnt=%b sel=%0d rv=%b exp gnt=1000 sel=3 rv=0000",
                 c, gnt, sel, rvalid);
      end
    end
  endtask

  // Locked burst keeps requestor 2 while 0 waits; unlock resumes rotation.
  task automatic test_lock();
    do_reset(4'b0100, 4'b0000, 4'b0100);
    tick();
    req = 4'b0101;
    n_checks++;
    if (gnt !== 4'b0100) begin
      n_errors++;
      $display("FAIL lock_first got gnt=%b exp gnt=0100", gnt);
    end
    for (int c = 1; c < 5; c++) begin
      tick();
      n_checks++;
      if (gnt !== 4'b0100 || sel !== 2'd2) begin
        n_errors++;
        $display("FAIL lock_hold[%0d] got gnt=%b sel=%0d exp gnt=0100 sel=2", c, gnt, sel);
      end
    end
    lock = 4'b0000;
    tick();
    n_checks++;
    if (gnt !== 4'b0001 || sel !== 2'd0) begin
      n_errors++;
      $display("FAIL lock_release got gnt=%b sel=%0d exp gnt=0001 sel=0", gnt, sel);
    end
    req = 4'b0110;
    tick();
    n_checks++;
    if (gnt !== 4'b0010 || sel !== 2'd1) begin
      n_errors++;
      $display("FAIL lock_ptr_next got gnt=%b sel=%0d exp gnt=0010 sel=1", gnt, sel);
    end
  endtask

  // Idle keeps sel, drops sel_valid, and does not move the pointer.
  task automatic test_idle_hold();
    do_reset(4'b0100, 4'b0000, 4'b0000);
    tick();
    req = 4'b0000;
    tick();
    n_checks++;
    if (gnt !== 4'b0000 || sel_valid !== 1'b0 || sel !== 2'd2) begin
      n_errors++;
      $display("FAIL idle_sel_hold got gnt=%b sv=%b sel=%0d exp gnt=0000 sv=0 sel=2",
               gnt, sel_valid, sel);
    end
    req = 4'b0110;
    tick();
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_errors++;
      $display("FAIL idle_ptr_kept got gnt=%b exp gnt=0010", gnt);
    end
  endtask

  // Reset while a read is in flight drops it and restarts from pointer 0.
  task automatic test_reset_mid_read();
    do_reset(4'b0010, 4'b0010, 4'b0000);
    tick();
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_errors++;
      $display("FAIL midrd_grant got gnt=%b exp gnt=0010", gnt);
    end
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    req  = 4'b1001;
    rd   = 4'b0000;
    n_checks++;
    if (gnt !== 4'b0000 || sel_valid !== 1'b0 || rvalid !== 4'b0000 || rvalid2 !== 4'b0000) begin
      n_errors++;
      $display("FAIL midrd_reset got gnt=%b sv=%b rv=%b rv2=%b exp all 0",
               gnt, sel_valid, rvalid, rvalid2);
    end
    tick();
    n_checks++;
    if (gnt !== 4'b0001 || rvalid !== 4'b0000 || rvalid2 !== 4'b0000) begin
      n_errors++;
      $display("FAIL midrd_restart got gnt=%b rv=%b rv2=%b exp gnt=0001 rv=0000 rv2=0000",
               gnt, rvalid, rvalid2);
    end
    tick();
    n_checks++;
    if (gnt !== 4'b1000 || rvalid2 !== 4'b0000) begin
      n_errors++;
      $display("FAIL midrd_after got gnt=%b rv2=%b exp gnt=1000 rv2=0000", gnt, rvalid2);
    end
  endtask

  // Grant to the last index wraps the pointer to 0.
  task automatic test_wrap();
    do_reset(4'b0100, 4'b0000, 4'b0000);
    tick();
    req = 4'b1000;
    tick();
    n_checks++;
    if (gnt !== 4'b1000 || sel !== 2'd3) begin
      n_errors++;
      $display("FAIL wrap_last got gnt=%b sel=%0d exp gnt=1000 sel=3", gnt, sel);
    end
    req = 4'b1001;
    tick();
    n_checks++;
    if (gnt !== 4'b0001 || sel !== 2'd0) begin
      n_errors++;
      $display("FAIL wrap_to_zero got gnt=%b sel=%0d exp gnt=0001 sel=0", gnt, sel);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst  = 1'b1;
    req  = 4'b0000;
    rd   = 4'b0000;
    lock = 4'b0000;
    test_reset();
    test_round_robin();
    test_sparse_and_writes();
    test_lock();
    test_idle_hold();
    test_reset_mid_read();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/buffer_access_arbiter.md
Name: buffer_access_arbiter

Overview:
Round-robin arbiter that sits directly upstream of the buffer address/data bus mux. It decides which of MUX_NUM compute-side requestors owns the shared single-port buffer in each cycle, and drives the mux select. Read responses return after a fixed RAM read latency, and the block tracks them and tags each one back to the requestor that issued it. It supports locked bursts, so one requestor can keep the buffer across consecutive cycles.

Parameters:
MUX_NUM, 64, number of requestors sharing one buffer
SELECT_W, $clog2(MUX_NUM), width of select/index values
RD_LAT, 1, cycles from a granted read access to valid R_data at the buffer (≥1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
req  input  MUX_NUM  per-requestor access request, level
rd  input  MUX_NUM  per-requestor access type with req: 1 = read, 0 = write
lock  input  MUX_NUM  per-requestor burst hold; keeps grant while asserted with req
gnt  output  MUX_NUM  one-hot registered grant; gnt[i]=1 means requestor i drives the buffer this cycle
sel  output  SELECT_W  binary index of the current owner; feeds mux sel
sel_valid  output  1  high when gnt is non-zero (buffer access occurs this cycle)
rvalid  output  MUX_NUM  one-hot; rvalid[i]=1 means buffer R_data this cycle belongs to requestor i
rsel  output  SELECT_W  index of the rvalid owner, for return-data routing

Behaviour:
- Reset (rst=1 at a clock edge):
  - gnt=0, sel=0, sel_valid=0, rvalid=0, rsel=0.
  - Round-robin pointer=0, so channel 0 has highest priority first.
  - Read-tracking pipeline is flushed; reads in flight at reset are dropped and never produce rvalid.
- Arbitration, evaluated each cycle, result registered into gnt/sel/sel_valid at the next edge:
  - HOLD: owner o is granted, lock[o]=1 and req[o]=1 → o is granted again; the pointer does not move.
  - ARB: otherwise, grant the first i with req[i]=1, searching pointer, pointer+1, … with wrap modulo MUX_NUM. The pointer becomes (i+1) mod MUX_NUM; wrap from MUX_NUM-1 goes to 0.
  - IDLE: no req → gnt=0, sel_valid=0; sel holds its last value; the pointer is unchanged.
- Grant latency: a req first seen at edge N gives gnt in the cycle after edge N at the earliest (1-cycle latency).
- The requestor must hold req, rd and its addr/data until it sees gnt. Each cycle with gnt[i]=1 is exactly one buffer access.
- Back-to-back grants are allowed: a different owner may follow in the very next cycle, with no bubble.
- Deasserting req[i] while gnt[i]=1: the access in that cycle still counts, and arbitration moves on at the next edge.
- Fairness: with all req high and no lock, grants rotate 0,1,2,…,MUX_NUM-1,0. No requestor waits more than MUX_NUM-1 grant cycles unless lock bursts are held.
- Read tracking:
  - A cycle with sel_valid=1, req[sel]=1 and rd[sel]=1 pushes {sel, 1} into an RD_LAT-deep shift pipeline; other cycles push {x, 0}.
  - Pipeline output drives rvalid (one-hot decode) and rsel.
  - Reads and rvalid may overlap every cycle; there is no backpressure and no loss.
  - Writes never produce rvalid.
- sel is always in range 0..MUX_NUM-1, and gnt is always one-hot or zero.
- Reset asserted mid-burst or mid-read aborts immediately; the next arbitration restarts from pointer 0.

Test Plan:
- Reset, then req=0 → gnt=0, sel_valid=0, rvalid=0 for 10 cycles; sel=0.
- MUX_NUM=4, req=4'b1111, lock=0, all reads → gnt sequence 0001,0010,0100,1000,0001. rvalid repeats that sequence delayed by RD_LAT=1, with rsel 0,1,2,3.
- req=4'b1010 from reset → grants alternate idx1, idx3, idx1. With req={3}, rd=0 only → gnt[3] every cycle and rvalid stays 0.
- lock[2]=1 with req[2] held for 5 cycles while req[0] is high → gnt[2] for 5 consecutive cycles. Drop lock[2] → gnt[0] next cycle, and the pointer then favours 1.
- Read granted to idx 3 at cycle 7, rst=1 at cycle 7 edge with RD_LAT=2 → no rvalid in cycles 8-9; gnt=0 after reset.
- Single req[MUX_NUM-1] with the pointer at MUX_NUM-1 → granted. The pointer wraps to 0, and a subsequent req={0,MUX_NUM-1} grants 0 first.
